// File: rtl/mbm_mul_scheduler.sv
// Round-robin scheduler sharing one iterative Booth multiplier core between two
// requesters, with a watchdog that turns a missing done strobe into an error response.
module mbm_mul_scheduler #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req0_valid,
  input  logic signed [WIDTH-1:0]     req0_a,
  input  logic signed [WIDTH-1:0]     req0_b,
  output logic                        req0_ready,
  input  logic                        req1_valid,
  input  logic signed [WIDTH-1:0]     req1_a,
  input  logic signed [WIDTH-1:0]     req1_b,
  output logic                        req1_ready,
  output logic                        mul_start,
  output logic signed [WIDTH-1:0]     mul_a,
  output logic signed [WIDTH-1:0]     mul_b,
  input  logic                        mul_done,
  input  logic signed [2*WIDTH-1:0]   mul_product,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_id,
  output logic signed [2*WIDTH-1:0]   rsp_product,
  output logic                        rsp_err,
  output logic                        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int              CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;
  logic             grant_id;
  logic             grant_any;
  logic             idle_ok;
  logic             accept;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    idle_ok   = (state == S_IDLE) && !rst;
    accept    = idle_ok && grant_any;
  end

  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept &&  grant_id;
  assign mul_start  = (state == S_ISSUE);
  assign rsp_valid  = (state == S_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      last_grant  <= 1'b1;
      cnt         <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      rsp_id      <= 1'b0;
      rsp_product <= '0;
      rsp_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            mul_a      <= grant_id ? req1_a : req0_a;
            mul_b      <= grant_id ? req1_b : req0_b;
            rsp_id     <= grant_id;
            last_grant <= grant_id;
            busy       <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A done in the watchdog's final cycle still counts as success.
          if (mul_done) begin
            rsp_product <= mul_product;
            rsp_err     <= 1'b0;
            state       <= S_RESP;
          end else if (cnt == CNT_LAST) begin
            rsp_product <= '0;
            rsp_err     <= 1'b1;
            state       <= S_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          if (rsp_ready) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
